// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared types for the instruction cache. It provides the
//                word type, the cache FSM state encoding and a saturating
//                increment helper used by the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

  // Stops counting at all-ones so that long runs never wrap.
  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + word_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped, read-only, one-word-per-frame instruction
//                cache. Hits are served combinationally. Misses are fetched
//                from the memory controller through an IDLE/MISS FSM.
//                Saturating hit and miss counters are provided.
//  Ports       : CLK, RST          clock, synchronous active-high reset
//                imemREN/imemaddr  fetch request / byte address
//                imemload/ihit     instruction word / hit indication
//                iinval            invalidate all frames
//                iREN/iaddr        memory read request / word address
//                iload/iwait       memory read data / busy
//                hit_count         saturating count of hit cycles
//                miss_count        saturating count of misses
//  Revision    : 1.0 - initial release
// ============================================================================
module icache
  import icache_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  input  logic        iinval,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } icachef_t;

  // Frame storage: valid bits are reset, tag/data are not.
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  word_t            data_q [SETS];

  icache_state_t state_q, state_d;
  logic [29:0]   miss_waddr_q;   // word address of the outstanding miss
  word_t         hit_count_q, miss_count_q;

  icachef_t req;
  icachef_t mreq;
  logic     tag_match;
  logic     hit_raw;
  logic     miss_start;
  logic     fill;
  logic     unused_bytoff;

  assign req           = icachef_t'(imemaddr);
  assign mreq          = icachef_t'({miss_waddr_q, 2'b00});
  assign unused_bytoff = ^{req.bytoff, mreq.bytoff};
  assign tag_match     = valid_q[req.idx] && (tag_q[req.idx] == req.tag);

  always_comb begin
    state_d    = state_q;
    hit_raw    = 1'b0;
    miss_start = 1'b0;
    fill       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          if (imemREN && tag_match) begin
            hit_raw  = 1'b1;
            imemload = data_q[req.idx];
          end else if (imemREN && !iinval) begin
            miss_start = 1'b1;
            state_d    = MISS;
          end
        end
        MISS: begin
          iREN  = 1'b1;
          iaddr = {miss_waddr_q, 2'b00};
          // Invalidate aborts the read outright, even if data arrives now.
          if (iinval) begin
            state_d = IDLE;
          end else if (!iwait) begin
            fill    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ihit       = hit_raw;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_waddr_q <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (iinval) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[mreq.idx] <= 1'b1;
      end
      if (miss_start) begin
        miss_waddr_q <= imemaddr[31:2];
        miss_count_q <= sat_inc(miss_count_q);
      end
      if (hit_raw) begin
        hit_count_q <= sat_inc(hit_count_q);
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bit guards their contents.
  always_ff @(posedge CLK) begin
    if (!RST && !iinval && fill) begin
      tag_q[mreq.idx]  <= mreq.tag;
      data_q[mreq.idx] <= iload;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache
//  Description : Directed testbench for icache with a small scoreboard of
//                expected miss addresses and fill data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        iinval;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  icache #(.SETS(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .imemload   (imemload),
    .ihit       (ihit),
    .iinval     (iinval),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iload      (iload),
    .iwait      (iwait),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a fetch that must miss, serves it after nwait busy cycles and
  // checks the resulting hit. Leaves the bench in IDLE with the hit shown.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] data, input int nwait);
    int n;
    int budget;
    logic [31:0] ea;
    logic [31:0] ed;
    iwait    = 1'b1;
    imemREN  = 1'b1;
    imemaddr = addr;
    exp_addr_q.push_back({addr[31:2], 2'b00});
    exp_data_q.push_back(data);
    #1;
    chk("miss_detect_ihit", {31'd0, ihit}, 32'd0);
    tick();
    budget = 0;
    while (!iREN && budget < 4) begin
      tick();
      budget++;
    end
    chk("miss_iren_seen", {31'd0, iREN}, 32'd1);
    ea = exp_addr_q.pop_front();
    chk("miss_iaddr", iaddr, ea);
    n = 0;
    repeat (nwait) begin
      if (iREN) n++;
      tick();
    end
    iwait = 1'b0;
    iload = data;
    #1;
    if (iREN) n++;
    chk("miss_iren_cycles", n, nwait + 1);
    tick();
    iwait = 1'b1;
    iload = 32'hDEAD_BEEF;
    #1;
    ed = exp_data_q.pop_front();
    chk("fill_ihit", {31'd0, ihit}, 32'd1);
    chk("fill_imemload", imemload, ed);
    chk("fill_iren_low", {31'd0, iREN}, 32'd0);
  endtask

  initial begin
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = '0;
    iinval   = 1'b0;
    iload    = '0;
    iwait    = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    RST = 1'b0;

    // Cold miss with three busy cycles
    do_miss(32'h40, 32'h2008000A, 3);
    chk("cold_miss_count", miss_count, 32'd1);
    chk("cold_hit_count_pre", hit_count, 32'd0);
    tick();
    chk("cold_hit_count", hit_count, 32'd1);

    // No request: no hit, no counter change
    imemREN = 1'b0;
    #1;
    chk("noreq_ihit", {31'd0, ihit}, 32'd0);
    tick();
    chk("noreq_hit_count", hit_count, 32'd1);
    chk("noreq_miss_count", miss_count, 32'd1);

    // Conflict on index 0
    do_miss(32'h440, 32'hAAAA0440, 0);
    do_miss(32'h40, 32'h2008000A, 1);
    chk("conflict_miss_count", miss_count, 32'd3);
    chk("conflict_hit_count", hit_count, 32'd1);

    // Redirect mid-miss: 0x84 (index 1) then PC moves to 0x108 (index 2)
    imemREN  = 1'b1;
    imemaddr = 32'h84;
    exp_addr_q.push_back(32'h84);
    #1;
    chk("redir_detect", {31'd0, ihit}, 32'd0);
    tick();
    imemaddr = 32'h108;
    #1;
    chk("redir_iaddr_held", iaddr, exp_addr_q.pop_front());
    iwait = 1'b0;
    iload = 32'h8484_8484;
    tick();
    iwait = 1'b1;
    #1;
    chk("redir_new_misses", {31'd0, ihit}, 32'd0);
    exp_addr_q.push_back(32'h108);
    tick();
    chk("redir_new_iren", {31'd0, iREN}, 32'd1);
    chk("redir_new_iaddr", iaddr, exp_addr_q.pop_front());
    iwait = 1'b0;
    iload = 32'h1081_0810;
    tick();
    iwait = 1'b1;
    #1;
    chk("redir_new_hit", imemload, 32'h1081_0810);
    imemaddr = 32'h84;
    #1;
    chk("redir_stale_hit", {31'd0, ihit}, 32'd1);
    chk("redir_stale_data", imemload, 32'h8484_8484);
    tick();
    chk("redir_hit_count", hit_count, 32'd2);
    chk("redir_miss_count", miss_count, 32'd5);

    // Invalidate during MISS with iwait=0 in the same cycle
    imemaddr = 32'h0C;
    #1;
    tick();
    chk("inval_in_miss", {31'd0, iREN}, 32'd1);
    iinval = 1'b1;
    iwait  = 1'b0;
    iload  = 32'h0BAD_0BAD;
    tick();
    iinval  = 1'b0;
    iwait   = 1'b1;
    imemREN = 1'b0;
    #1;
    chk("inval_idle", {31'd0, iREN}, 32'd0);
    do_miss(32'h40, 32'h2008000A, 0);
    chk("inval_miss_count", miss_count, 32'd7);
    chk("inval_hit_count", hit_count, 32'd2);
    imemaddr = 32'h0C;
    #1;
    chk("inval_no_fill", {31'd0, ihit}, 32'd0);
    imemREN = 1'b0;

    // Reset mid-miss
    imemREN  = 1'b1;
    imemaddr = 32'h300;
    #1;
    tick();
    chk("rstmid_iren_before", {31'd0, iREN}, 32'd1);
    RST = 1'b1;
    tick();
    chk("rstmid_iren", {31'd0, iREN}, 32'd0);
    chk("rstmid_hit_count", hit_count, 32'd0);
    chk("rstmid_miss_count", miss_count, 32'd0);
    RST   = 1'b0;
    iwait = 1'b0;
    do_miss(32'h40, 32'h1234_5678, 0);
    chk("rstmid_refetch_miss", miss_count, 32'd1);

    // Hit counter saturation
    force dut.hit_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_count_q;
    repeat (3) begin
      tick();
      chk("sat_hit_count", hit_count, 32'hFFFF_FFFF);
    end
    chk("sat_miss_count", miss_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipeline fetch stage and the memory controller. Serves fetches from the PC (imemREN/imemaddr) with a combinational hit path. On a miss, fetches the word from the memory controller (iREN/iaddr/iload/iwait) through a two-state FSM. Keeps saturating hit/miss counters for performance runs.

## Interface
- SETS, 16: number of one-word frames; power of two, 2..1024
- IDX_W, $clog2(SETS): index width; tag width TAG_W = 30 - IDX_W
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- imemREN  in  1  fetch request from datapath
- imemaddr  in  32  fetch byte address (word_t); bits [1:0] ignored
- imemload  out  32  instruction word; valid when ihit=1
- ihit  out  1  fetch satisfied this cycle
- iinval  in  1  invalidate all frames (one cycle pulse)
- iREN  out  1  read request to memory controller
- iaddr  out  32  word-aligned miss address to memory controller
- iload  in  32  memory read data, valid when iwait=0
- iwait  in  1  memory busy; 0 with iREN=1 completes the read
- hit_count  out  32  saturating count of hit cycles
- miss_count  out  32  saturating count of misses (MISS entries)

## Operation
- Address split: tag = imemaddr[31:IDX_W+2], index = imemaddr[IDX_W+1:2], byte offset [1:0] ignored.
- Frame = {valid, tag[TAG_W], data[32]}; SETS frames held in flops.
- FSM states: IDLE, MISS.
- IDLE:
  - ihit = imemREN & frame[index].valid & tag match; imemload = frame[index].data when hit, else 0.
  - On imemREN & ~hit & ~iinval: latch the word address into miss_addr, increment miss_count, go to MISS.
  - iREN=0, iaddr=0.
- MISS:
  - iREN=1, iaddr = {miss_addr[31:2],2'b00}; ihit=0; imemload=0.
  - On iwait=0: write frame[miss_addr index] = {1, miss tag, iload}; go to IDLE.
- iinval (any state): clear every valid bit next edge.
  - In MISS, abort the read: FSM goes to IDLE and no fill occurs, even if iwait=0 in the same cycle.
  - In IDLE, a miss is not started in that cycle; a hit is still reported that cycle.
- The fill uses the latched miss_addr, never the live imemaddr. If the PC changes mid-miss (branch redirect), the stale line still fills and the new address is checked in IDLE.
- imemREN=0 in IDLE: no hit, no miss, no counter change.
- Counters: hit_count increments on every cycle with ihit=1. Both counters hold at 32'hFFFFFFFF. Neither counter is cleared by iinval.

## Timing
- Reset (RST high at edge): state IDLE, all valid=0, miss_addr=0, counters=0.
  - During reset, outputs are ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0.
  - Tag/data contents need not be reset.
- Hit latency 0: ihit is combinational from imemaddr in the same cycle.
- Miss latency: cycle 0 detects the miss (IDLE). MISS is entered from cycle 1. Fill happens on the edge ending the first MISS cycle with iwait=0. ihit=1 in the next IDLE cycle if imemaddr is unchanged.
  - Minimum is 2 cycles from request to ihit (iwait=0 immediately).
- iREN stays high continuously for the whole MISS state; the memory controller may hold iwait=1 any number of cycles.
- RST mid-miss: FSM goes to IDLE and valid bits clear. The next memory response is ignored because iREN drops immediately.
- Only one frame write per edge. iinval has priority over the fill.

## Structure
- Add to cpu_types_pkg:
  - icachef_t packed struct {tag, idx, bytoff}
  - icache_frame_t {valid, tag, data}
  - icache_state_t enum {IDLE, MISS}
- Widths come from SETS via localparams.
- Single module; frame array, FSM and counters inline. No sub-module needed.
- Hooks into caches alongside dcache, on the datapath_cache_if / caches_if modports.

## Test plan
- Cold miss: after reset, imemREN=1, imemaddr=0x40, iwait=1 for 3 cycles then 0 with iload=0x2008000A -> iREN high 4 cycles with iaddr=0x40; ihit=1, imemload=0x2008000A next cycle; miss_count=1.
- Hit then conflict (SETS=16): 0x40 resident; fetch 0x440 (same index 0, different tag) -> miss; fill 0x440; re-fetch 0x40 -> miss again.
- Redirect mid-miss: miss on 0x80, imemaddr changes to 0x100 during MISS -> iaddr stays 0x80; the 0x80 frame fills; the 0x100 miss starts the following IDLE cycle.
- Invalidate: iinval pulse during MISS with iwait=0 in the same cycle -> no fill. Previously resident 0x40 now misses; counters unchanged except the new miss.
- Reset mid-miss: RST during MISS -> iREN=0 next cycle, all frames invalid, counters 0.
- Counter saturation: force hit_count to 32'hFFFFFFFE, hold 3 hit cycles -> value stays 32'hFFFFFFFF.
